// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port RAM between instruction fetch and data-stage requests
// Data requests win over fetches; each transaction is IDLE -> DATA/INST -> DONE with a fixed RAM latency.
module mem_port_arbiter #(
    parameter int WORD_LEN    = 32,
    parameter int ADDRESS_LEN = 32,
    parameter int LATENCY     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_req,
    input  logic [ADDRESS_LEN-1:0] if_addr,
    output logic [WORD_LEN-1:0]    if_rdata,
    output logic                   if_ready,
    output logic                   if_stall,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [ADDRESS_LEN-1:0] mem_addr,
    input  logic [WORD_LEN-1:0]    mem_wdata,
    output logic [WORD_LEN-1:0]    mem_rdata,
    output logic                   mem_ready,
    output logic                   mem_stall,
    output logic                   ram_en,
    output logic                   ram_we,
    output logic [ADDRESS_LEN-1:0] ram_addr,
    output logic [WORD_LEN-1:0]    ram_wdata,
    input  logic [WORD_LEN-1:0]    ram_rdata
);

    typedef enum logic [1:0] {IDLE, DATA, INST, DONE} state_t;

    localparam logic [3:0] LAT4 = 4'(LATENCY);

    state_t     state;
    logic [3:0] cnt;
    logic       is_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            is_write  <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            if_rdata  <= '0;
            mem_rdata <= '0;
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
        end else begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_read || mem_write) begin
                        state     <= DATA;
                        ram_en    <= 1'b1;
                        ram_we    <= mem_write;
                        is_write  <= mem_write;
                        ram_addr  <= mem_addr;
                        ram_wdata <= mem_wdata;
                        cnt       <= LAT4;
                    end else if (if_req) begin
                        state     <= INST;
                        ram_en    <= 1'b1;
                        is_write  <= 1'b0;
                        ram_addr  <= if_addr;
                        cnt       <= LAT4;
                    end
                end
                DATA: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        // Stores keep the previous load result visible on mem_rdata.
                        if (!is_write) begin
                            mem_rdata <= ram_rdata;
                        end
                        mem_ready <= 1'b1;
                        state     <= DONE;
                    end
                end
                INST: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        if_rdata <= ram_rdata;
                        if_ready <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign if_stall  = if_req & ~if_ready;
    assign mem_stall = (mem_read | mem_write) & ~mem_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with a latency-accurate RAM model
module tb_mem_port_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        if_stall;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_stall;
    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    mem_port_arbiter #(.WORD_LEN(32), .ADDRESS_LEN(32), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_ready(if_ready), .if_stall(if_stall),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .mem_stall(mem_stall),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_wdata;
    } cmd_t;

    typedef struct {
        logic        inst;
        logic [31:0] rdata;
    } rdy_t;

    cmd_t        cmd_q[$];
    rdy_t        rdy_q[$];
    logic [31:0] mdl_mem[logic [31:0]];
    logic [31:0] ram_mem[logic [31:0]];
    logic [31:0] last_mr;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          age = 0;
    int          en_cycle = 0;
    int          prev_en = -1;
    cmd_t        mc;
    rdy_t        mr;

    function automatic logic [31:0] init_val(logic [31:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] mdl_rd(logic [31:0] a);
        return mdl_mem.exists(a) ? mdl_mem[a] : init_val(a);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: data is only correct during the LAT-th cycle after the command cycle begins.
    always @(negedge clk) begin
        if (rst) begin
            age = 0;
        end else if (ram_en) begin
            age = 1;
            if (ram_we) ram_mem[ram_addr] = ram_wdata;
        end else if (age > 0 && age < 40) begin
            age = age + 1;
        end
        if (age == LAT)
            ram_rdata = ram_mem.exists(ram_addr) ? ram_mem[ram_addr] : init_val(ram_addr);
        else
            ram_rdata = 32'hBAD00000 | 32'(age);
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ctl", {60'd0, ram_en, ram_we, if_ready, mem_ready}, 64'd0);
            chk("rst_ram_addr", {32'd0, ram_addr}, 64'd0);
            chk("rst_ram_wdata", {32'd0, ram_wdata}, 64'd0);
            chk("rst_rdata", {if_rdata, mem_rdata}, 64'd0);
            cmd_q.delete();
            rdy_q.delete();
            prev_en = -1;
        end else begin
            chk("if_stall", {63'd0, if_stall}, {63'd0, if_req & ~if_ready});
            chk("mem_stall", {63'd0, mem_stall}, {63'd0, (mem_read | mem_write) & ~mem_ready});
            chk("ready_excl", {63'd0, if_ready & mem_ready}, 64'd0);
            if (ram_we && !ram_en) chk("we_without_en", {63'd0, ram_we}, 64'd0);
            if (ram_en) begin
                if (cmd_q.size() == 0) begin
                    chk("unexpected_ram_en", {63'd0, ram_en}, 64'd0);
                end else begin
                    mc = cmd_q.pop_front();
                    chk("ram_we", {63'd0, ram_we}, {63'd0, mc.we});
                    chk("ram_addr", {32'd0, ram_addr}, {32'd0, mc.addr});
                    if (mc.chk_wdata) chk("ram_wdata", {32'd0, ram_wdata}, {32'd0, mc.wdata});
                end
                if (prev_en >= 0) chk("accept_spacing_ok", {63'd0, (cyc - prev_en) >= LAT + 2}, 64'd1);
                prev_en  = cyc;
                en_cycle = cyc;
            end
            if (if_ready || mem_ready) begin
                if (rdy_q.size() == 0) begin
                    chk("unexpected_ready", {62'd0, if_ready, mem_ready}, 64'd0);
                end else begin
                    mr = rdy_q.pop_front();
                    chk("ready_kind", {63'd0, if_ready}, {63'd0, mr.inst});
                    if (mr.inst) chk("if_rdata", {32'd0, if_rdata}, {32'd0, mr.rdata});
                    else         chk("mem_rdata", {32'd0, mem_rdata}, {32'd0, mr.rdata});
                    chk("ready_latency", 64'(cyc - en_cycle), 64'(LAT));
                end
            end
        end
    end

    task automatic push_data(input logic we, input logic [31:0] a, input logic [31:0] wd);
        cmd_q.push_back('{we, a, wd, 1'b1});
        if (we) mdl_mem[a] = wd;
        else    last_mr = mdl_rd(a);
        rdy_q.push_back('{1'b0, last_mr});
    endtask

    task automatic push_fetch(input logic [31:0] a);
        cmd_q.push_back('{1'b0, a, 32'd0, 1'b0});
        rdy_q.push_back('{1'b1, mdl_rd(a)});
    endtask

    task automatic idle_inputs();
        if_req = 0; mem_read = 0; mem_write = 0;
    endtask

    task automatic wait_done(input bit want_if, input bit want_mem, input bit drop_on_en,
                             output int t_if, output int t_mem);
        int n = 0;
        bit got_if = !want_if;
        bit got_mem = !want_mem;
        t_if = 0;
        t_mem = 0;
        while (!(got_if && got_mem) && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (drop_on_en && ram_en) idle_inputs();
            if (mem_ready) begin got_mem = 1; t_mem = cyc; mem_read = 0; mem_write = 0; end
            if (if_ready)  begin got_if = 1;  t_if = cyc;  if_req = 0; end
        end
        chk("completion", {62'd0, got_if, got_mem}, 64'd3);
        idle_inputs();
    endtask

    // kind: 0 fetch, 1 load, 2 store, 3 read+write, 4 fetch+load, 5 fetch+store
    task automatic issue(input int kind, input logic [31:0] a, input logic [31:0] fa,
                         input logic [31:0] wd, input bit drop);
        int t_if, t_mem;
        bit has_data = (kind != 0);
        bit has_if = (kind == 0 || kind >= 4);
        bit we = (kind == 2 || kind == 3 || kind == 5);
        if (has_data) push_data(we, a, wd);
        if (has_if) push_fetch(fa);
        mem_addr  = a;
        mem_wdata = wd;
        if_addr   = fa;
        mem_read  = (kind == 1 || kind == 3 || kind == 4);
        mem_write = we;
        if_req    = has_if;
        wait_done(has_if, has_data, drop, t_if, t_mem);
        if (kind >= 4) chk("collision_gap", 64'(t_if - t_mem), 64'(LAT + 2));
    endtask

    task automatic back_to_back(input logic [31:0] a);
        int en_t[3];
        int k = 0, r = 0, n = 0;
        for (int i = 0; i < 3; i++) push_fetch(a);
        if_addr = a;
        if_req  = 1;
        while (r < 3 && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (ram_en && k < 3) begin en_t[k] = cyc; k++; end
            if (if_ready) begin r++; if (r == 3) if_req = 0; end
        end
        idle_inputs();
        chk("b2b_count", {32'(k), 32'(r)}, {32'd3, 32'd3});
        chk("b2b_spacing0", 64'(en_t[1] - en_t[0]), 64'(LAT + 2));
        chk("b2b_spacing1", 64'(en_t[2] - en_t[1]), 64'(LAT + 2));
    endtask

    task automatic reset_mid_txn(input logic [31:0] a);
        int n = 0, t_if, t_mem;
        mem_addr = a;
        mem_read = 1;
        while (!ram_en && n < 20) begin @(posedge clk); #1; n++; end
        chk("rst_test_accept", {63'd0, ram_en}, 64'd1);
        rst = 1;
        last_mr = 32'd0;
        #1;
        chk("rst_async_clear", {62'd0, ram_en, mem_ready}, 64'd0);
        repeat (2) begin @(posedge clk); #1; end
        push_data(1'b0, a, mem_wdata);
        rst = 0;
        wait_done(1'b0, 1'b1, 1'b0, t_if, t_mem);
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        if_addr = 0; mem_addr = 0; mem_wdata = 0;
        ram_rdata = 0;
        last_mr = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;

        issue(0, 32'h0, 32'h10, 32'h0, 1'b0);
        chk("fetch_deadbeef", {32'd0, if_rdata}, 64'hDEADBEEF);
        issue(2, 32'h8, 32'h0, 32'h1234, 1'b0);
        issue(1, 32'h8, 32'h0, 32'h0, 1'b0);
        chk("load_after_store", {32'd0, mem_rdata}, 64'h1234);
        issue(4, 32'h40, 32'h10, 32'h0, 1'b0);
        issue(3, 32'h44, 32'h0, 32'hA5A5_0001, 1'b0);
        back_to_back(32'h20);
        reset_mid_txn(32'h8);

        for (int i = 0; i < 60; i++) begin
            int kind = int'($urandom_range(0, 5));
            bit drop = (kind < 4) && ($urandom_range(0, 3) == 0);
            issue(kind, 32'($urandom_range(0, 15)) << 2, 32'($urandom_range(0, 15)) << 2,
                  $urandom, drop);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        repeat (6) begin @(posedge clk); #1; end
        chk("drain", 64'(cmd_q.size() + rdy_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
